// File: rtl/boe_sched_if.sv
// Requester-side and engine-side signals of the BOE frame scheduler.
// master = requesters/engine model, slave = scheduler.
interface boe_sched_if;
  logic       req0, req1;
  logic [2:0] num0, num1;
  logic [7:0] din0, din1;
  logic       gnt0, gnt1;
  logic       eng_start;
  logic [2:0] eng_num;
  logic [7:0] eng_data;
  logic       busy, done, err;

  modport master (
    output req0, req1, num0, num1, din0, din1,
    input  gnt0, gnt1, eng_start, eng_num, eng_data, busy, done, err
  );

  modport slave (
    input  req0, req1, num0, num1, din0, din1,
    output gnt0, gnt1, eng_start, eng_num, eng_data, busy, done, err
  );
endinterface

// File: rtl/boe_sched.sv
// Two-requester round-robin scheduler feeding one shared BOE engine:
// grants a frame of N bytes, waits for the engine drain, then signals done.
module boe_sched #(
  parameter int DRAIN_EXTRA = 3
) (
  input logic       clk,
  input logic       rst,
  boe_sched_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic [3:0] cnt;
  logic       last;     // last served requester; 1 => requester 1
  logic       win;      // owner of the frame in flight
  logic [2:0] num_q;
  logic [7:0] data_q;
  logic       start_q;
  logic       err_q;

  logic       any_req;
  logic       pick;
  logic [2:0] pick_num;
  logic [3:0] load_last;
  logic [3:0] drain_last;

  assign any_req  = bus.req0 | bus.req1;
  // On a tie the requester not served last wins.
  assign pick     = (bus.req0 & bus.req1) ? ~last : bus.req1;
  assign pick_num = pick ? bus.num1 : bus.num0;

  assign load_last  = {1'b0, num_q} - 4'd1;
  assign drain_last = {1'b0, num_q} + 4'(DRAIN_EXTRA) - 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= 1'b1;
      win     <= 1'b0;
      num_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            win   <= pick;
            num_q <= pick_num;
            cnt   <= '0;
            // Zero-length frames are rejected on the spot; the pointer still
            // advances so a stuck N=0 requester cannot starve the other one.
            if (pick_num == 3'd0) begin
              err_q <= 1'b1;
              last  <= pick;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          data_q  <= win ? bus.din1 : bus.din0;
          start_q <= (cnt == 4'd0);
          if (cnt == load_last) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DRAIN: begin
          if (cnt == drain_last) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          last  <= win;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = (state == LOAD) & ~win;
  assign bus.gnt1      = (state == LOAD) &  win;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.eng_start = start_q;
  assign bus.eng_num   = num_q;
  assign bus.eng_data  = data_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_boe_sched.sv
// Bench for boe_sched: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a frame-timeline model.
module tb_boe_sched;
  localparam int DE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  boe_sched_if bus ();

  boe_sched #(.DRAIN_EXTRA(DE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a frame decided in cycle s with length n owns cycles s+1 .. s+2n+DE+1;
  // grants in s+1..s+n, engine start in s+2, done in the last owned cycle.
  int         cyc    = 0;
  bit         m_act  = 0;
  int         m_s    = 0;
  int         m_n    = 0;
  int         m_w    = 0;
  bit         m_ptr  = 1;
  int         m_free = 0;
  int         m_err  = -1;
  logic [7:0] m_data = '0;
  logic [2:0] m_num  = '0;

  always @(negedge clk) begin
    int e_end;
    bit in_g;
    int w;
    logic [2:0] nn;
    cyc++;
    if (rst) begin
      m_act = 0; m_ptr = 1; m_data = '0; m_num = '0; m_err = -1; m_free = cyc + 1;
      chk("rst_gnt0",  32'(bus.gnt0), 0);
      chk("rst_gnt1",  32'(bus.gnt1), 0);
      chk("rst_start", 32'(bus.eng_start), 0);
      chk("rst_num",   32'(bus.eng_num), 0);
      chk("rst_data",  32'(bus.eng_data), 0);
      chk("rst_busy",  32'(bus.busy), 0);
      chk("rst_done",  32'(bus.done), 0);
      chk("rst_err",   32'(bus.err), 0);
    end else begin
      e_end = m_s + 2*m_n + DE + 1;
      in_g  = m_act && cyc > m_s && cyc <= m_s + m_n;
      chk("gnt0",  32'(bus.gnt0), 32'(in_g && m_w == 0));
      chk("gnt1",  32'(bus.gnt1), 32'(in_g && m_w == 1));
      chk("start", 32'(bus.eng_start), 32'(m_act && cyc == m_s + 2));
      chk("busy",  32'(bus.busy), 32'(m_act && cyc > m_s && cyc <= e_end));
      chk("done",  32'(bus.done), 32'(m_act && cyc == e_end));
      chk("err",   32'(bus.err), 32'(cyc == m_err));
      chk("num",   32'(bus.eng_num), 32'(m_num));
      chk("data",  32'(bus.eng_data), 32'(m_data));
      if (in_g) m_data = (m_w == 1) ? bus.din1 : bus.din0;
      if (cyc >= m_free && (bus.req0 || bus.req1)) begin
        if (bus.req0 && bus.req1) w = m_ptr ? 0 : 1;
        else                      w = bus.req1 ? 1 : 0;
        nn = (w == 1) ? bus.num1 : bus.num0;
        m_num = nn;
        m_ptr = (w == 1);
        if (nn == 3'd0) begin
          m_err  = cyc + 1;
          m_free = cyc + 1;
        end else begin
          m_act = 1; m_s = cyc; m_n = int'(nn); m_w = w;
          m_free = cyc + 2*int'(nn) + DE + 2;
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && bus.busy; i++) tick();
    chk(name, 32'(bus.busy), 0);
    tick();
  endtask

  bit         pend [2];
  logic [2:0] rn   [2];

  initial begin
    int k;
    int wins[$];
    bit p0, p1, raised;
    int cg, cb, cd;
    bit g [2];

    bus.req0 = 0; bus.req1 = 0; bus.num0 = '0; bus.num1 = '0;
    bus.din0 = '0; bus.din1 = '0;
    repeat (3) tick();

    // Single frame N=3 from requester 0
    rst = 0; bus.req0 = 1; bus.num0 = 3;
    for (int i = 0; i < 10 && !bus.gnt0; i++) tick();
    chk("single_gnt_wait", 32'(bus.gnt0), 1);
    bus.din0 = 8'h10; bus.req0 = 0;
    tick();
    chk("single_gnt_b1",  32'(bus.gnt0), 1);
    chk("single_data0",   32'(bus.eng_data), 32'h10);
    chk("single_start0",  32'(bus.eng_start), 1);
    chk("single_num",     32'(bus.eng_num), 3);
    bus.din0 = 8'h30;
    tick();
    chk("single_data1",   32'(bus.eng_data), 32'h30);
    chk("single_start1",  32'(bus.eng_start), 0);
    bus.din0 = 8'h20;
    tick();
    chk("single_gnt_fall", 32'(bus.gnt0), 0);
    chk("single_data2",    32'(bus.eng_data), 32'h20);
    k = 0;
    while (k < 12 && !bus.done) begin tick(); k++; end
    chk("single_done_gap", 32'(k), 6);
    wait_idle("single_idle");

    // Tie right after reset: requester 0 first, requester 1 nine cycles later
    rst = 1; tick(); tick();
    rst = 0; bus.req0 = 1; bus.req1 = 1; bus.num0 = 2; bus.num1 = 2;
    for (int i = 0; i < 10 && !(bus.gnt0 || bus.gnt1); i++) tick();
    chk("tie_first_gnt0", 32'(bus.gnt0), 1);
    chk("tie_first_gnt1", 32'(bus.gnt1), 0);
    bus.req0 = 0;
    k = 0;
    while (k < 30 && !bus.gnt1) begin tick(); k++; end
    chk("tie_gap", 32'(k), 9);
    bus.req1 = 0;
    wait_idle("tie_idle");

    // Zero-length request is rejected with a single err pulse
    bus.req1 = 1; bus.num1 = 0;
    tick();
    bus.req1 = 0;
    chk("zero_err",  32'(bus.err), 1);
    chk("zero_gnt1", 32'(bus.gnt1), 0);
    chk("zero_busy", 32'(bus.busy), 0);
    tick();
    chk("zero_err_end", 32'(bus.err), 0);
    chk("zero_busy2",   32'(bus.busy), 0);

    // Reset at the 4th byte of an N=7 frame
    bus.req0 = 1; bus.num0 = 7;
    for (int i = 0; i < 10 && !bus.gnt0; i++) tick();
    chk("abort_gnt_wait", 32'(bus.gnt0), 1);
    bus.din0 = 8'hA0; bus.req0 = 0;
    repeat (3) begin tick(); bus.din0 = bus.din0 + 8'h1; end
    chk("abort_gnt4",  32'(bus.gnt0), 1);
    chk("abort_data2", 32'(bus.eng_data), 32'hA2);
    rst = 1;
    #1;
    chk("abort_gnt0",  32'(bus.gnt0), 0);
    chk("abort_busy",  32'(bus.busy), 0);
    chk("abort_num",   32'(bus.eng_num), 0);
    chk("abort_data",  32'(bus.eng_data), 0);
    tick();
    rst = 0;
    cd = 0;
    repeat (20) begin tick(); if (bus.done) cd++; end
    chk("abort_no_done", 32'(cd), 0);
    bus.req0 = 1; bus.num0 = 2;
    for (int i = 0; i < 10 && !bus.gnt0; i++) tick();
    chk("abort_regrant", 32'(bus.gnt0), 1);
    bus.req0 = 0;
    wait_idle("abort_idle");

    // Maximum length frame
    bus.req0 = 1; bus.num0 = 7;
    cg = 0; cb = 0; cd = 0;
    repeat (40) begin
      tick();
      if (bus.gnt0) begin cg++; bus.req0 = 0; end
      if (bus.busy) cb++;
      if (bus.done) cd++;
    end
    chk("max_gnt_cycles",  32'(cg), 7);
    chk("max_busy_cycles", 32'(cb), 18);
    chk("max_done_pulses", 32'(cd), 1);

    // Round robin: req0 held, req1 raised during requester 0's drain
    bus.req0 = 1; bus.num0 = 1;
    p0 = 0; p1 = 0; raised = 0;
    for (int i = 0; i < 80 && wins.size() < 3; i++) begin
      tick();
      if (bus.gnt0 && !p0) wins.push_back(0);
      if (bus.gnt1 && !p1) wins.push_back(1);
      if (!raised && wins.size() == 1 && bus.busy && !bus.gnt0) begin
        bus.req1 = 1; bus.num1 = 1; raised = 1;
      end
      if (bus.gnt1) bus.req1 = 0;
      p0 = bus.gnt0; p1 = bus.gnt1;
    end
    while (wins.size() < 3) wins.push_back(9);
    chk("rr_win0", 32'(wins[0]), 0);
    chk("rr_win1", 32'(wins[1]), 1);
    chk("rr_win2", 32'(wins[2]), 0);
    bus.req0 = 0; bus.req1 = 0;
    wait_idle("rr_idle");

    // Randomized traffic: held requests, zero lengths, sticky re-requests, resets
    pend[0] = 0; pend[1] = 0; rn[0] = '0; rn[1] = '0;
    repeat (3000) begin
      tick();
      g[0] = bus.gnt0; g[1] = bus.gnt1;
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          if (g[i])             pend[i] = ($urandom_range(0, 3) == 0);
          else if (rn[i] == 0)  pend[i] = 0;
        end else if ($urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          rn[i]   = 3'($urandom_range(0, 7));
        end else begin
          rn[i] = 3'($urandom);
        end
      end
      bus.req0 = pend[0]; bus.num0 = rn[0]; bus.din0 = 8'($urandom);
      bus.req1 = pend[1]; bus.num1 = rn[1]; bus.din1 = 8'($urandom);
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 0; bus.req0 = 0; bus.req1 = 0;
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/boe_sched.md
BOE_SCHED -- requirements
Module: boe_sched

Interface
REQ-001 Parameter DRAIN_EXTRA, default 3: drain cycles the engine needs beyond N after its last input byte.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req0 / req1  input  1 each  frame request from requester 0 / requester 1; level, held until granted.
REQ-005 num0 / num1  input  3 each  frame length N (bytes) of requester 0 / 1; stable while its req is high.
REQ-006 din0 / din1  input  8 each  frame byte of requester 0 / 1; byte k valid on the k-th cycle its gnt is high.
REQ-007 gnt0 / gnt1  output  1 each  grant; high for exactly N consecutive cycles during the transfer.
REQ-008 eng_start  output  1  one-cycle pulse alongside the first byte of a frame to the shared BOE engine.
REQ-009 eng_num  output  3  latched N of the frame in transfer, driven to the engine.
REQ-010 eng_data  output  8  registered frame byte to the engine.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  one-cycle pulse when the engine has finished the current frame.
REQ-013 err  output  1  one-cycle pulse when a frame with N=0 is rejected.

Function
REQ-014 The state machine SHALL have exactly four states: IDLE, LOAD, DRAIN, DONE.
REQ-015 IDLE: if any req is high, pick a winner, latch its num into eng_num, clear cnt, go to LOAD (N>0) or reject (N=0).
REQ-016 Arbitration: a single requester wins outright; if both req are high, the requester not served last wins (round-robin).
REQ-017 The last-served pointer SHALL reset to "requester 1", so requester 0 wins the first tie.
REQ-018 LOAD timing: the winner's gnt is high for N cycles, starting the cycle after the IDLE decision.
REQ-019 In each LOAD cycle, eng_data <= din of the granted requester, so bytes appear at the engine one cycle later.
REQ-020 eng_start SHALL be high in the cycle eng_data carries byte 0 only.
REQ-021 LOAD counting: cnt increments each cycle; when cnt==N-1, gnt drops, cnt clears, and the state goes to DRAIN.
REQ-022 DRAIN SHALL last N+DRAIN_EXTRA cycles, then go to DONE.
REQ-023 DONE SHALL last one cycle: done=1, the last-served pointer updates to the winner, and the state returns to IDLE.
REQ-024 N=0 rejection: no gnt, no eng_start, err pulses one cycle after the IDLE decision, the pointer updates, and the state stays IDLE.
REQ-025 Minimum gap between consecutive grants SHALL be 2N+DRAIN_EXTRA+2 cycles (LOAD N, DRAIN N+DRAIN_EXTRA, DONE 1, IDLE 1).
REQ-026 req deassertion or num change during LOAD/DRAIN SHALL be ignored; the transfer completes with the latched N.
REQ-027 req high outside IDLE SHALL only be queued; its arbitration happens in IDLE.
REQ-028 gnt0 and gnt1 SHALL never be high simultaneously.
REQ-029 cnt SHALL be 4 bits, so N+DRAIN_EXTRA ≤ 15 holds for any DRAIN_EXTRA ≤ 8; N=7 is the maximum.

Reset
REQ-030 On rst=1, immediately (asynchronously): state=IDLE, cnt=0, pointer=requester 1.
REQ-031 On rst=1, all outputs are 0: gnt0, gnt1, eng_start, eng_num, eng_data, busy, done, err.
REQ-032 Reset asserted mid-LOAD or mid-DRAIN SHALL abort the frame with no done pulse.
REQ-033 After rst deasserts, the first IDLE cycle SHALL arbitrate normally.

Verification
REQ-034 Single frame: req0=1, num0=3, din0 = 0x10, 0x30, 0x20 on the grant cycles -> gnt0 high 3 cycles; eng_data 0x10/0x30/0x20 delayed 1 cycle; eng_start with 0x10; done 6 cycles after gnt0 falls.
REQ-035 Tie after reset: req0=req1=1, num=2 each -> gnt0 first; then gnt1 with first grant cycle 9 cycles after gnt0's first grant cycle.
REQ-036 Round-robin: req0 held continuously, req1 pulses during requester 0's DRAIN -> requester 1 served next, then requester 0.
REQ-037 Zero length: req1=1, num1=0 -> err one cycle, gnt1 never high, busy stays 0.
REQ-038 Reset during the LOAD of an N=7 frame at its 4th byte -> all outputs 0 immediately, no done; a new req0 afterwards is served normally.
REQ-039 Max length: N=7 with DRAIN_EXTRA=3 -> gnt high 7 cycles, DRAIN 10 cycles, exactly one done pulse, busy high for 18 cycles.
